bfly_mux_seq_ctrl: RTL and testbench
====================================

// Module: bfly_mux_seq_ctrl
// PURPOSE
//   Parametrised add/sub mux sequencer for the radix-2 FFT butterfly shift-register stages.
//   Per accepted start: NUM_BLK blocks, each HALF valid samples on the add path
//   (mux_sel=0), then HALF valid samples on the sub path (mux_sel=1).
//   Counts only on valid_in (stall-tolerant). Reports busy, block index, done and first-sample markers.
//   One instance per FFT stage, driven by the previous stage's alert_mod output.
// PARAMETERS
//   HALF    16  samples per half-block (power of 2, >=2); stage span = 2*HALF
//   NUM_BLK 1   blocks per frame (>=1); stage s of N-pt FFT: HALF=N>>(s+1), NUM_BLK=1<<s
//   CW      $clog2(HALF)                 derived, sample counter width (localparam)
//   BW      $clog2(NUM_BLK) (min 1)      derived, block counter width (localparam)
// PORTS
//   clk        in   1   clock
//   rstn       in   1   async active-low reset
//   alert      in   1   start request; sampled only in IDLE or on final sample (see below)
//   valid_in   in   1   sample present this cycle; counters advance only when 1
//   mux_sel    out  1   0=add path, 1=sub path; registered
//   first_smp  out  1   registered; 1 during the first sample slot of each half-block
//   blk_idx    out  BW  current block index, registered
//   busy       out  1   1 in ADD_SEL/SUB_SEL
//   done       out  1   one-cycle pulse after last SUB sample of last block accepted
//   overrun    out  1   [BFLY_CTRL_ERR_EN only] sticky error flag
//   clr_err    in   1   [BFLY_CTRL_ERR_EN only] synchronous clear of overrun
// BEHAVIOUR
//   Reset (async, rstn=0): state=IDLE, cnt=0, blk=0, mux_sel=0, first_smp=0, blk_idx=0,
//     busy=0, done=0, overrun=0. Reset mid-frame aborts immediately; no done.
//   FSM states IDLE, ADD_SEL, SUB_SEL; all outputs registered, no comb path in->out.
//   IDLE: alert=1 at edge k -> ADD_SEL from k+1, mux_sel=0, cnt=0, blk=0, first_smp=1.
//     valid_in not required to start.
//   ADD_SEL: on valid_in: cnt++ (mod HALF), first_smp=0. At cnt==HALF-1 & valid_in:
//     -> SUB_SEL, mux_sel=1, cnt=0, first_smp=1.
//   SUB_SEL: on valid_in: cnt++. At cnt==HALF-1 & valid_in:
//     blk<NUM_BLK-1: -> ADD_SEL, mux_sel=0, blk++, first_smp=1.
//     blk==NUM_BLK-1: done=1 next cycle; -> IDLE, mux_sel=0, blk=0, unless alert=1 the same cycle.
//       In that case -> ADD_SEL directly (back-to-back frame, no idle bubble), done still pulses.
//   valid_in=0: state, cnt, blk, mux_sel and first_smp all hold.
//   alert while busy (except on the final-sample cycle): ignored.
//   Wrap: cnt wraps HALF-1->0 exactly at phase change; never exceeds HALF-1.
//   Latency: mux_sel changes in the cycle after the accepting edge of the last sample of a half.
// CONFIGURATION
//   BFLY_CTRL_ERR_EN defined: overrun/clr_err ports exist. overrun sets (sticky) when alert=1 while
//     busy, except on the back-to-back final-sample cycle.
//     clr_err=1 clears it next edge. If set and clear occur in the same cycle, set wins.
//   Undefined: ports absent; ignored alerts are silent. All other behaviour is identical.
// STRUCTURE
//   Package fft_ctrl_pkg: typedef enum logic [1:0] {IDLE, ADD_SEL, SUB_SEL} bfly_state_t;
//     MUX_ADD=1'b0, MUX_SUB=1'b1 constants.
//   Sub-module mod_cnt #(MOD): enable-gated modulo counter with clear and last-count flag.
//     Instantiated twice: sample counter (MOD=HALF) and block counter (MOD=NUM_BLK).
//   Top: FSM plus output registers only.
// TESTING
//   1 HALF=16,NUM_BLK=1, valid_in=1, alert pulse -> mux_sel 0 for 16 cycles, 1 for 16,
//     done at cycle 33, busy high 32 cycles
//   2 HALF=4,NUM_BLK=4 -> pattern 0000 1111 x4, blk_idx 0..3, first_smp every 4 cycles,
//     single done after 32 valid cycles
//   3 valid_in toggling 1,0 -> each phase spans 2*HALF cycles; outputs hold on valid_in=0
//   4 alert on final SUB sample -> done pulse, next ADD_SEL starts next cycle, blk_idx=0, no IDLE cycle
//   5 rstn low at ADD cnt=7 -> all outputs 0 async; fresh alert restarts cleanly with full 16 adds
//   6 ERR_EN: alert mid-ADD -> overrun=1 persists, sequence unaffected; clr_err -> 0;
//     set and clear in the same cycle -> stays 1

Source files
------------

// File: rtl/bfly_mux_seq_ctrl_pkg.sv
// Shared types and constants for the FFT butterfly add/sub mux sequencer.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD_SEL,
    SUB_SEL
  } bfly_state_t;

  localparam logic MUX_ADD = 1'b0;
  localparam logic MUX_SUB = 1'b1;

  // Counter width that stays at least one bit for a modulus of 1.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bfly_mux_seq_ctrl_if.sv
// Handshake/status bundle of the butterfly mux sequencer.
// BFLY_CTRL_ERR_EN adds the overrun flag and its clear.
interface bfly_mux_seq_ctrl_if #(
  parameter int unsigned BW = 1
);
  logic          alert;
  logic          valid_in;
  logic          mux_sel;
  logic          first_smp;
  logic [BW-1:0] blk_idx;
  logic          busy;
  logic          done;
`ifdef BFLY_CTRL_ERR_EN
  logic          overrun;
  logic          clr_err;
`endif

  modport master (
    output alert,
    output valid_in,
`ifdef BFLY_CTRL_ERR_EN
    output clr_err,
    input  overrun,
`endif
    input  mux_sel,
    input  first_smp,
    input  blk_idx,
    input  busy,
    input  done
  );

  modport slave (
    input  alert,
    input  valid_in,
`ifdef BFLY_CTRL_ERR_EN
    input  clr_err,
    output overrun,
`endif
    output mux_sel,
    output first_smp,
    output blk_idx,
    output busy,
    output done
  );

endinterface

// File: rtl/bfly_mux_seq_ctrl_cnt.sv
// Enable-gated modulo-MOD counter with synchronous clear and last-count flag.
module mod_cnt #(
  parameter  int unsigned MOD = 2,
  localparam int unsigned W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= last_o ? '0 : cnt_q + W'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == W'(MOD - 1));

endmodule

// File: rtl/bfly_mux_seq_ctrl.sv
// Add/sub mux sequencer for one radix-2 FFT butterfly stage.
// Optional BFLY_CTRL_ERR_EN: sticky overrun flag for alerts arriving while busy.
module bfly_mux_seq_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned HALF    = 16,
  parameter int unsigned NUM_BLK = 1
) (
  input logic               clk,
  input logic               rstn,
  bfly_mux_seq_ctrl_if.slave bus
);

  localparam int unsigned CW = clog2_min1(HALF);
  localparam int unsigned BW = clog2_min1(NUM_BLK);

  bfly_state_t   state_q;
  logic          mux_sel_q;
  logic          first_smp_q;
  logic          done_q;
  logic [CW-1:0] smp_cnt;
  logic          smp_last;
  logic [BW-1:0] blk_cnt;
  logic          blk_last;
  logic          busy;
  logic          smp_en;
  logic          blk_en;
  logic          idle;
  logic          final_smp;

  assign busy      = (state_q != IDLE);
  assign idle      = (state_q == IDLE);
  assign smp_en    = busy && bus.valid_in;
  assign blk_en    = smp_en && (state_q == SUB_SEL) && smp_last;
  assign final_smp = blk_en && blk_last;

  // Both counters wrap on their own at the phase/frame boundary; clear only guards IDLE.
  mod_cnt #(.MOD(HALF)) u_smp_cnt (
    .clk_i  (clk),
    .rst_ni (rstn),
    .en_i   (smp_en),
    .clr_i  (idle),
    .cnt_o  (smp_cnt),
    .last_o (smp_last)
  );

  mod_cnt #(.MOD(NUM_BLK)) u_blk_cnt (
    .clk_i  (clk),
    .rst_ni (rstn),
    .en_i   (blk_en),
    .clr_i  (idle),
    .cnt_o  (blk_cnt),
    .last_o (blk_last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      mux_sel_q   <= MUX_ADD;
      first_smp_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= final_smp;
      unique case (state_q)
        IDLE: begin
          if (bus.alert) begin
            state_q     <= ADD_SEL;
            mux_sel_q   <= MUX_ADD;
            first_smp_q <= 1'b1;
          end
        end
        ADD_SEL: begin
          if (bus.valid_in) begin
            first_smp_q <= (smp_cnt == CW'(HALF - 1));
            if (smp_last) begin
              state_q   <= SUB_SEL;
              mux_sel_q <= MUX_SUB;
            end
          end
        end
        SUB_SEL: begin
          if (bus.valid_in) begin
            first_smp_q <= (smp_cnt == CW'(HALF - 1));
            if (smp_last) begin
              mux_sel_q <= MUX_ADD;
              // An alert on the final sample chains straight into the next frame.
              if (!blk_last || bus.alert) begin
                state_q <= ADD_SEL;
              end else begin
                state_q     <= IDLE;
                first_smp_q <= 1'b0;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mux_sel   = mux_sel_q;
  assign bus.first_smp = first_smp_q;
  assign bus.blk_idx   = blk_cnt;
  assign bus.busy      = busy;
  assign bus.done      = done_q;

`ifdef BFLY_CTRL_ERR_EN
  logic overrun_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun_q <= 1'b0;
    end else if (bus.alert && busy && !final_smp) begin
      overrun_q <= 1'b1;
    end else if (bus.clr_err) begin
      overrun_q <= 1'b0;
    end
  end

  assign bus.overrun = overrun_q;
`endif

endmodule

// File: tb/tb_bfly_mux_seq_ctrl.sv
// Bench for bfly_mux_seq_ctrl: two instances (16x1 and 4x4) against a frame-position model.
module tb_bfly_mux_seq_ctrl;

  localparam int unsigned HA  = 16;
  localparam int unsigned NA  = 1;
  localparam int unsigned HB  = 4;
  localparam int unsigned NB  = 4;
  localparam int unsigned BWA = 1;
  localparam int unsigned BWB = 2;
  localparam int unsigned HALF_T [2] = '{HA, HB};
  localparam int unsigned TOT_T  [2] = '{2 * HA * NA, 2 * HB * NB};
`ifdef BFLY_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic alert_r [2];
  logic valid_r [2];
  logic clr_r   [2];

  int checks = 0;
  int errors = 0;

  bfly_mux_seq_ctrl_if #(.BW(BWA)) ifA ();
  bfly_mux_seq_ctrl_if #(.BW(BWB)) ifB ();

  assign ifA.alert    = alert_r[0];
  assign ifA.valid_in = valid_r[0];
  assign ifB.alert    = alert_r[1];
  assign ifB.valid_in = valid_r[1];

  bfly_mux_seq_ctrl #(.HALF(HA), .NUM_BLK(NA)) dut_a (.clk(clk), .rstn(rstn), .bus(ifA));
  bfly_mux_seq_ctrl #(.HALF(HB), .NUM_BLK(NB)) dut_b (.clk(clk), .rstn(rstn), .bus(ifB));

  logic ovr_a, ovr_b;
`ifdef BFLY_CTRL_ERR_EN
  assign ifA.clr_err = clr_r[0];
  assign ifB.clr_err = clr_r[1];
  assign ovr_a = ifA.overrun;
  assign ovr_b = ifB.overrun;
`else
  assign ovr_a = 1'b0;
  assign ovr_b = 1'b0;
`endif

  // {overrun, busy, mux_sel, first_smp, done, blk_idx zero-extended to 8}
  logic [12:0] act_vec [2];
  assign act_vec[0] = {ovr_a, ifA.busy, ifA.mux_sel, ifA.first_smp, ifA.done, 8'(ifA.blk_idx)};
  assign act_vec[1] = {ovr_b, ifB.busy, ifB.mux_sel, ifB.first_smp, ifB.done, 8'(ifB.blk_idx)};

  // Reference: a frame is just a count of accepted samples; outputs follow arithmetically.
  bit          m_act  [2];
  int unsigned m_pos  [2];
  bit          m_done [2];
  bit          m_ovr  [2];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int d = 0; d < 2; d++) begin
        m_act[d]  <= 1'b0;
        m_pos[d]  <= 0;
        m_done[d] <= 1'b0;
        m_ovr[d]  <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_done[d] <= m_act[d] && valid_r[d] && (m_pos[d] == TOT_T[d] - 1);
        if (m_act[d] && alert_r[d] && !(valid_r[d] && (m_pos[d] == TOT_T[d] - 1)))
          m_ovr[d] <= 1'b1;
        else if (clr_r[d])
          m_ovr[d] <= 1'b0;
        if (!m_act[d]) begin
          if (alert_r[d]) begin
            m_act[d] <= 1'b1;
            m_pos[d] <= 0;
          end
        end else if (valid_r[d]) begin
          if (m_pos[d] == TOT_T[d] - 1) begin
            m_pos[d] <= 0;
            m_act[d] <= alert_r[d];
          end else begin
            m_pos[d] <= m_pos[d] + 1;
          end
        end
      end
    end
  end

  function automatic logic [12:0] exp_vec(input int d);
    int unsigned h;
    logic        mux, first;
    logic [7:0]  b;
    h     = HALF_T[d];
    mux   = m_act[d] && ((m_pos[d] % (2 * h)) >= h);
    first = m_act[d] && ((m_pos[d] % h) == 0);
    b     = m_act[d] ? 8'(m_pos[d] / (2 * h)) : 8'd0;
    return {ERR_EN & m_ovr[d], m_act[d], mux, first, m_done[d], b};
  endfunction

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      alert_r[d] = 1'b1;
      valid_r[d] = 1'b1;
      clr_r[d]   = 1'b0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_vec[d] !== 13'd0) begin
        errors++;
        $display("FAIL reset_state dut%0d got %h exp %h", d, act_vec[d], 13'd0);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      alert_r[d] = 1'b0;
      valid_r[d] = 1'b0;
    end
    rstn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL reset_idle dut%0d got %h exp %h", d, act_vec[d], exp_vec(d));
        end
      end
    end
  endtask

  task automatic test_single_frame();
    int busy_n = 0, mux1_n = 0, done_n = 0, done_at = 0;
    alert_r[0] = 1'b1;
    valid_r[0] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      alert_r[0] = 1'b0;
      checks++;
      if (act_vec[0] !== exp_vec(0)) begin
        errors++;
        $display("FAIL single_frame cyc %0d got %h exp %h", c, act_vec[0], exp_vec(0));
      end
      if (ifA.busy)    busy_n++;
      if (ifA.mux_sel) mux1_n++;
      if (ifA.done) begin
        done_n++;
        done_at = c;
      end
    end
    valid_r[0] = 1'b0;
    checks += 4;
    if (busy_n != 32) begin errors++; $display("FAIL single_busy_len got %0d exp 32", busy_n); end
    if (mux1_n != 16) begin errors++; $display("FAIL single_sub_len got %0d exp 16", mux1_n); end
    if (done_at != 33) begin errors++; $display("FAIL single_done_cyc got %0d exp 33", done_at); end
    if (done_n != 1) begin errors++; $display("FAIL single_done_cnt got %0d exp 1", done_n); end
  endtask

  task automatic test_multi_block();
    int done_n = 0, first_n = 0, blk_max = 0, done_at = 0;
    alert_r[1] = 1'b1;
    valid_r[1] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      alert_r[1] = 1'b0;
      checks++;
      if (act_vec[1] !== exp_vec(1)) begin
        errors++;
        $display("FAIL multi_block cyc %0d got %h exp %h", c, act_vec[1], exp_vec(1));
      end
      if (ifB.first_smp) first_n++;
      if (int'(ifB.blk_idx) > blk_max) blk_max = int'(ifB.blk_idx);
      if (ifB.done) begin
        done_n++;
        done_at = c;
      end
    end
    valid_r[1] = 1'b0;
    checks += 4;
    if (first_n != 8) begin errors++; $display("FAIL multi_first_cnt got %0d exp 8", first_n); end
    if (blk_max != 3) begin errors++; $display("FAIL multi_blk_max got %0d exp 3", blk_max); end
    if (done_n != 1) begin errors++; $display("FAIL multi_done_cnt got %0d exp 1", done_n); end
    if (done_at != 33) begin errors++; $display("FAIL multi_done_cyc got %0d exp 33", done_at); end
  endtask

  task automatic test_stall();
    int add_n = 0, busy_n = 0, done_at = 0;
    alert_r[0] = 1'b1;
    valid_r[0] = 1'b0;
    for (int c = 1; c <= 72; c++) begin
      @(negedge clk);
      alert_r[0] = 1'b0;
      checks++;
      if (act_vec[0] !== exp_vec(0)) begin
        errors++;
        $display("FAIL stall cyc %0d got %h exp %h", c, act_vec[0], exp_vec(0));
      end
      if (ifA.busy && !ifA.mux_sel) add_n++;
      if (ifA.busy) busy_n++;
      if (ifA.done) done_at = c;
      valid_r[0] = (c % 2 == 0);
    end
    valid_r[0] = 1'b0;
    checks += 3;
    if (add_n != 32) begin errors++; $display("FAIL stall_add_len got %0d exp 32", add_n); end
    if (busy_n != 64) begin errors++; $display("FAIL stall_busy_len got %0d exp 64", busy_n); end
    if (done_at != 65) begin errors++; $display("FAIL stall_done_cyc got %0d exp 65", done_at); end
  endtask

  task automatic test_back_to_back();
    int done_n = 0, busy_n = 0;
    alert_r[1] = 1'b1;
    valid_r[1] = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      checks++;
      if (act_vec[1] !== exp_vec(1)) begin
        errors++;
        $display("FAIL b2b cyc %0d got %h exp %h", c, act_vec[1], exp_vec(1));
      end
      if (c == 33) begin
        checks++;
        if (act_vec[1] !== {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0}) begin
          errors++;
          $display("FAIL b2b_restart got %h exp %h", act_vec[1], {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0});
        end
      end
      if (ifB.done) done_n++;
      if (ifB.busy) busy_n++;
      alert_r[1] = (c == 32);
    end
    valid_r[1] = 1'b0;
    checks += 2;
    if (done_n != 2) begin errors++; $display("FAIL b2b_done_cnt got %0d exp 2", done_n); end
    if (busy_n != 64) begin errors++; $display("FAIL b2b_busy_len got %0d exp 64", busy_n); end
  endtask

  task automatic test_async_reset();
    int add_n = 0, done_n = 0;
    alert_r[0] = 1'b1;
    valid_r[0] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      alert_r[0] = 1'b0;
      checks++;
      if (act_vec[0] !== exp_vec(0)) begin
        errors++;
        $display("FAIL areset_pre cyc %0d got %h exp %h", c, act_vec[0], exp_vec(0));
      end
    end
    #2 rstn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_vec[d] !== 13'd0) begin
        errors++;
        $display("FAIL areset_async dut%0d got %h exp %h", d, act_vec[d], 13'd0);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (act_vec[0] !== exp_vec(0)) begin
      errors++;
      $display("FAIL areset_idle got %h exp %h", act_vec[0], exp_vec(0));
    end
    alert_r[0] = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      alert_r[0] = 1'b0;
      checks++;
      if (act_vec[0] !== exp_vec(0)) begin
        errors++;
        $display("FAIL areset_restart cyc %0d got %h exp %h", c, act_vec[0], exp_vec(0));
      end
      if (ifA.busy && !ifA.mux_sel) add_n++;
      if (ifA.done) done_n++;
    end
    valid_r[0] = 1'b0;
    checks += 2;
    if (add_n != 16) begin errors++; $display("FAIL areset_add_len got %0d exp 16", add_n); end
    if (done_n != 1) begin errors++; $display("FAIL areset_done_cnt got %0d exp 1", done_n); end
  endtask

`ifdef BFLY_CTRL_ERR_EN
  task automatic test_overrun();
    alert_r[0] = 1'b1;
    valid_r[0] = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      checks++;
      if (act_vec[0] !== exp_vec(0)) begin
        errors++;
        $display("FAIL overrun_seq cyc %0d got %h exp %h", c, act_vec[0], exp_vec(0));
      end
      if (c == 6 || c == 9 || c == 15 || c == 36) begin
        checks++;
        if (ifA.overrun !== 1'b1) begin
          errors++;
          $display("FAIL overrun_set cyc %0d got %b exp 1", c, ifA.overrun);
        end
      end
      if (c == 11) begin
        checks++;
        if (ifA.overrun !== 1'b0) begin
          errors++;
          $display("FAIL overrun_clr got %b exp 0", ifA.overrun);
        end
      end
      alert_r[0] = (c == 5) || (c == 14);
      clr_r[0]   = (c == 10) || (c == 14);
    end
    valid_r[0] = 1'b0;
    clr_r[0]   = 1'b1;
    @(negedge clk);
    clr_r[0]   = 1'b0;
    checks++;
    if (ifA.overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_final_clr got %b exp 0", ifA.overrun);
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL random dut%0d cyc %0d got %h exp %h", d, c, act_vec[d], exp_vec(d));
        end
        alert_r[d] = ($urandom_range(0, 11) == 0);
        valid_r[d] = ($urandom_range(0, 3) != 0);
        clr_r[d]   = ($urandom_range(0, 7) == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_multi_block();
    test_stall();
    test_back_to_back();
    test_async_reset();
`ifdef BFLY_CTRL_ERR_EN
    test_overrun();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
